// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: types and defaults shared by the bit-serial adder.
//   state_t   - controller states (IDLE -> ADD -> DONE -> IDLE)
//   DEF_WIDTH - default operand/sum width
package serial_adder_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: request/result bundle of the bit-serial adder.
//   start, a, b         - request side, driven by the master
//   busy, done, sum,    - status/result side, driven by the slave (adder)
//   carry
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;

  modport master (output start, a, b, input busy, done, sum, carry);
  modport slave  (input start, a, b, output busy, done, sum, carry);
endinterface

// File: rtl/full_adder.sv
// full_adder: one-bit full adder from two half adders and an OR.
//   a, b, cin -> sum, cout
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic s1, c1, c2;

  half_adder u_ha0 (.a(a),  .b(b),   .sum(s1),  .cout(c1));
  half_adder u_ha1 (.a(s1), .b(cin), .sum(sum), .cout(c2));

  // Both half-adder carries can never be high together, so OR suffices.
  assign cout = c1 | c2;
endmodule

// File: rtl/half_adder.sv
// half_adder: one-bit half adder.
//   a, b -> sum (a^b), cout (a&b)
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b;
  assign cout = a & b;
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit unsigned adder, LSB first, one bit
// per clock through a single full-adder cell plus a carry flip-flop.
//   clk, rst   - clock, asynchronous active-high reset
//   bus.start  - begin an addition (sampled in IDLE only)
//   bus.a/b    - operands, captured on the accepted start
//   bus.busy   - high during the WIDTH ADD cycles
//   bus.done   - one-cycle pulse; sum/carry valid from this cycle
//   bus.sum    - a+b mod 2^WIDTH, updated only on the edge into DONE
//   bus.carry  - carry-out of the MSB
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] sa, sb, ps;
  logic             cy;
  logic [CW-1:0]    cnt;
  logic             busy_q, done_q, carry_q;
  logic [WIDTH-1:0] sum_q;

  logic             fa_s, fa_c;
  logic [WIDTH-1:0] ps_next;

  full_adder u_fa (
    .a    (sa[0]),
    .b    (sb[0]),
    .cin  (cy),
    .sum  (fa_s),
    .cout (fa_c)
  );

  // New bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  assign ps_next = {fa_s, ps[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sa      <= '0;
      sb      <= '0;
      ps      <= '0;
      cy      <= 1'b0;
      cnt     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            sa     <= bus.a;
            sb     <= bus.b;
            cy     <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= ADD;
          end
        end
        ADD: begin
          ps  <= ps_next;
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          cy  <= fa_c;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            // Last bit: publish the full result in one step, never partials.
            sum_q   <= ps_next;
            carry_q <= fa_c;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          // start is deliberately not looked at here.
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.carry = carry_q;
endmodule
